// File: rtl/comparator_pkg.sv
// Shared types for the registered magnitude comparator.
// One-hot compare result and its reset encoding.
package comparator_pkg;

    typedef enum logic [2:0] {
        CMP_GT = 3'b100,
        CMP_LT = 3'b010,
        CMP_EQ = 3'b001
    } cmp_result_e;

    localparam cmp_result_e CMP_RESET_VAL = CMP_EQ;

endpackage

// File: rtl/comparator_core.sv
// Combinational magnitude compare of two operands.
// Signed mode biases the sign bit so one unsigned compare covers both.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_e      result
);

    localparam logic [WIDTH-1:0] MSB =
        WIDTH'(1) << (WIDTH - 1);

    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] ax;
    logic [WIDTH-1:0] bx;

    // Inverting the sign bit maps two's complement onto offset binary.
    assign flip = SIGNED ? MSB : '0;
    assign ax   = a ^ flip;
    assign bx   = b ^ flip;

    always_comb begin
        result = CMP_EQ;
        unique case (1'b1)
            (ax > bx): result = CMP_GT;
            (ax < bx): result = CMP_LT;
            default:   result = CMP_EQ;
        endcase
    end

endmodule

// File: rtl/magnitude_comparator.sv
// Registered magnitude comparator: one-hot greater/less/equal flags.
// Reset state reads as "0 == 0".
module magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             greater,
    output logic             less,
    output logic             equal
);

    cmp_result_e r_next;
    cmp_result_e r_q;
    logic [2:0]  r_bits;
    logic        unused_c;

    // c is reserved and deliberately goes nowhere.
    assign unused_c = &{1'b0, c};

    comparator_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .a      (a),
        .b      (b),
        .result (r_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= CMP_RESET_VAL;
        end else begin
            r_q <= r_next;
        end
    end

    assign r_bits  = r_q;
    assign greater = r_bits[2];
    assign less    = r_bits[1];
    assign equal   = r_bits[0];

endmodule

// File: tb/tb_magnitude_comparator.sv
// Directed bench for magnitude_comparator across four configurations.
// Each DUT pair shares operands: 1-bit and 8-bit, unsigned and signed.
module tb_magnitude_comparator;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       c;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic g1u, l1u, e1u;
    logic g1s, l1s, e1s;
    logic g8u, l8u, e8u;
    logic g8s, l8s, e8s;

    logic [2:0] f1u, f1s, f8u, f8s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign f1u = {g1u, l1u, e1u};
    assign f1s = {g1s, l1s, e1s};
    assign f8u = {g8u, l8u, e8u};
    assign f8s = {g8s, l8s, e8s};

    magnitude_comparator #(.WIDTH(1), .SIGNED(1'b0)) d1u (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c),
        .greater(g1u), .less(l1u), .equal(e1u)
    );

    magnitude_comparator #(.WIDTH(1), .SIGNED(1'b1)) d1s (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c),
        .greater(g1s), .less(l1s), .equal(e1s)
    );

    magnitude_comparator #(.WIDTH(8), .SIGNED(1'b0)) d8u (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c),
        .greater(g8u), .less(l8u), .equal(e8u)
    );

    magnitude_comparator #(.WIDTH(8), .SIGNED(1'b1)) d8s (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c),
        .greater(g8s), .less(l8s), .equal(e8s)
    );

    task automatic test_reset();
        rst = 1'b1;
        c   = 1'b0;
        a1  = 1'b1;
        b1  = 1'b0;
        a8  = 8'h01;
        b8  = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if ({f1u, f1s} !== {EQ, EQ}) begin
                $display("FAIL reset_w1[%0d]: got %b want %b",
                         i, {f1u, f1s}, {EQ, EQ});
                n_bad++;
            end
            n_cmp++;
            if ({f8u, f8s} !== {EQ, EQ}) begin
                $display("FAIL reset_w8[%0d]: got %b want %b",
                         i, {f8u, f8s}, {EQ, EQ});
                n_bad++;
            end
            n_cmp++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        if ({f1u, f1s} !== {GT, LT}) begin
            $display("FAIL reset_release_w1: got %b want %b",
                     {f1u, f1s}, {GT, LT});
            n_bad++;
        end
        n_cmp++;
        if ({f8u, f8s} !== {GT, GT}) begin
            $display("FAIL reset_release_w8: got %b want %b",
                     {f8u, f8s}, {GT, GT});
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_w1_sweep();
        logic       va [4];
        logic       vb [4];
        logic [2:0] eu [4];
        logic [2:0] es [4];
        va = '{1'b1, 1'b0, 1'b0, 1'b1};
        vb = '{1'b0, 1'b1, 1'b0, 1'b1};
        eu = '{GT, LT, EQ, EQ};
        es = '{LT, GT, EQ, EQ};
        for (int i = 0; i < 4; i++) begin
            a1 = va[i];
            b1 = vb[i];
            @(posedge clk);
            #1;
            if (f1u !== eu[i]) begin
                $display("FAIL w1u_sweep[%0d]: got %b want %b",
                         i, f1u, eu[i]);
                n_bad++;
            end
            n_cmp++;
            if (f1s !== es[i]) begin
                $display("FAIL w1s_sweep[%0d]: got %b want %b",
                         i, f1s, es[i]);
                n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_c_indep();
        a1 = 1'b1;
        b1 = 1'b1;
        a8 = 8'h5A;
        b8 = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            c = i[0];
            @(posedge clk);
            #1;
            if ({f1u, f1s, f8u, f8s} !== {4{EQ}}) begin
                $display("FAIL c_indep[%0d]: got %b want %b",
                         i, {f1u, f1s, f8u, f8s}, {4{EQ}});
                n_bad++;
            end
            n_cmp++;
        end
        c = 1'b0;
    endtask

    task automatic test_w8_compare();
        logic [7:0] va [7];
        logic [7:0] vb [7];
        logic [2:0] eu [7];
        logic [2:0] es [7];
        va = '{8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h01, 8'h80};
        vb = '{8'h00, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h02, 8'h7F};
        eu = '{GT, LT, EQ, EQ, LT, LT, GT};
        es = '{LT, GT, EQ, EQ, GT, LT, LT};
        for (int i = 0; i < 7; i++) begin
            a8 = va[i];
            b8 = vb[i];
            @(posedge clk);
            #1;
            if (f8u !== eu[i]) begin
                $display("FAIL w8u[%0d] %h:%h: got %b want %b",
                         i, va[i], vb[i], f8u, eu[i]);
                n_bad++;
            end
            n_cmp++;
            if (f8s !== es[i]) begin
                $display("FAIL w8s[%0d] %h:%h: got %b want %b",
                         i, va[i], vb[i], f8s, es[i]);
                n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [8];
        logic [7:0] vb [8];
        logic       vr [8];
        logic [2:0] eu [8];
        logic [2:0] es [8];
        logic [5:0] prev;
        va = '{8'h10, 8'h20, 8'hF0, 8'hF0,
               8'h01, 8'h00, 8'hFE, 8'h81};
        vb = '{8'h20, 8'h10, 8'h10, 8'h01,
               8'hF0, 8'h00, 8'hFF, 8'h80};
        vr = '{1'b0, 1'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0};
        eu = '{LT, GT, GT, EQ, LT, EQ, LT, GT};
        es = '{LT, GT, LT, EQ, GT, EQ, LT, GT};
        prev = {f8u, f8s};
        for (int i = 0; i < 8; i++) begin
            a8  = va[i];
            b8  = vb[i];
            rst = vr[i];
            #1;
            if ({f8u, f8s} !== prev) begin
                $display("FAIL b2b_hold[%0d]: got %b want %b",
                         i, {f8u, f8s}, prev);
                n_bad++;
            end
            n_cmp++;
            @(posedge clk);
            #1;
            if ({f8u, f8s} !== {eu[i], es[i]}) begin
                $display("FAIL b2b[%0d]: got %b want %b",
                         i, {f8u, f8s}, {eu[i], es[i]});
                n_bad++;
            end
            n_cmp++;
            if (!$onehot(f8u) || !$onehot(f8s)) begin
                $display("FAIL b2b_onehot[%0d]: got %b want one-hot",
                         i, {f8u, f8s});
                n_bad++;
            end
            n_cmp++;
            prev = {eu[i], es[i]};
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_w1_sweep();
        test_c_indep();
        test_w8_compare();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
